// File: rtl/axi_line_master_if.sv
// rtl/axi_line_master_if.sv - AXI4 master-side bus bundle for the cache line master
// Carries the five AXI channels; master drives requests, slave drives responses.
interface axi_line_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [7:0]            M_AXI_AWLEN;
    logic [2:0]            M_AXI_AWSIZE;
    logic [1:0]            M_AXI_AWBURST;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [31:0]           M_AXI_WDATA;
    logic [3:0]            M_AXI_WSTRB;
    logic                  M_AXI_WLAST;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]            M_AXI_ARLEN;
    logic [2:0]            M_AXI_ARSIZE;
    logic [1:0]            M_AXI_ARBURST;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [31:0]           M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RLAST;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
    );
endinterface

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - single-outstanding 32-byte line refill/writeback AXI4 master
// A line is eight 32-bit beats in one INCR burst; word k sits at bits [32k+31:32k].
module axi_line_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [255:0]          req_wdata,
    output logic                  resp_valid,
    output logic [255:0]          resp_rdata,
    output logic                  resp_err,
    axi_line_master_if.master     m_axi
);
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [255:0]          r_line;
    logic [255:0]          r_rdata;
    logic [2:0]            r_beat;
    logic                  r_err;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_b_hs;
    logic                  w_r_bad;

    assign w_aw_hs = (r_state == WR_AW_W) && !r_aw_done && m_axi.M_AXI_AWREADY;
    assign w_w_hs  = (r_state == WR_AW_W) && !r_w_done && m_axi.M_AXI_WREADY;
    assign w_r_hs  = (r_state == RD_R) && m_axi.M_AXI_RVALID;
    assign w_b_hs  = (r_state == WR_B) && m_axi.M_AXI_BVALID;
    // RLAST must appear on beat 7 and nowhere else.
    assign w_r_bad = (m_axi.M_AXI_RRESP != 2'b00) || (m_axi.M_AXI_RLAST != (r_beat == 3'd7));

    assign m_axi.M_AXI_AWADDR  = r_addr;
    assign m_axi.M_AXI_ARADDR  = r_addr;
    assign m_axi.M_AXI_AWLEN   = 8'd7;
    assign m_axi.M_AXI_ARLEN   = 8'd7;
    assign m_axi.M_AXI_AWSIZE  = 3'd2;
    assign m_axi.M_AXI_ARSIZE  = 3'd2;
    assign m_axi.M_AXI_AWBURST = 2'b01;
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_WDATA   = r_line[{r_beat, 5'd0} +: 32];
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WLAST   = (r_beat == 3'd7);
    assign resp_rdata          = r_rdata;

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next               = r_state;
        req_ready            = 1'b0;
        resp_valid           = 1'b0;
        resp_err             = 1'b0;
        m_axi.M_AXI_ARVALID  = 1'b0;
        m_axi.M_AXI_RREADY   = 1'b0;
        m_axi.M_AXI_AWVALID  = 1'b0;
        m_axi.M_AXI_WVALID   = 1'b0;
        m_axi.M_AXI_BREADY   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = req_wr ? WR_AW_W : RD_AR;
            end
            RD_AR: begin
                m_axi.M_AXI_ARVALID = 1'b1;
                if (m_axi.M_AXI_ARREADY) w_next = RD_R;
            end
            RD_R: begin
                m_axi.M_AXI_RREADY = 1'b1;
                if (w_r_hs && r_beat == 3'd7) w_next = DONE;
            end
            WR_AW_W: begin
                m_axi.M_AXI_AWVALID = !r_aw_done;
                m_axi.M_AXI_WVALID  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || (w_w_hs && r_beat == 3'd7)))
                    w_next = WR_B;
            end
            WR_B: begin
                m_axi.M_AXI_BREADY = 1'b1;
                if (m_axi.M_AXI_BVALID) w_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Reset silences the bus immediately rather than waiting for the edge.
        if (rst) begin
            req_ready           = 1'b1;
            resp_valid          = 1'b0;
            resp_err            = 1'b0;
            m_axi.M_AXI_ARVALID = 1'b0;
            m_axi.M_AXI_RREADY  = 1'b0;
            m_axi.M_AXI_AWVALID = 1'b0;
            m_axi.M_AXI_WVALID  = 1'b0;
            m_axi.M_AXI_BREADY  = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            r_addr    <= '0;
            r_line    <= '0;
            r_rdata   <= '0;
            r_beat    <= 3'd0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr    <= {req_addr[ADDR_WIDTH-1:5], 5'b0};
                    r_line    <= req_wdata;
                    r_beat    <= 3'd0;
                    r_err     <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
                RD_R: if (w_r_hs) begin
                    r_line[{r_beat, 5'd0} +: 32] <= m_axi.M_AXI_RDATA;
                    r_beat                       <= r_beat + 3'd1;
                    if (w_r_bad) r_err <= 1'b1;
                    // Publish the whole line only once it is complete.
                    if (r_beat == 3'd7) r_rdata <= {m_axi.M_AXI_RDATA, r_line[223:0]};
                end
                WR_AW_W: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs) begin
                        r_beat <= r_beat + 3'd1;
                        if (r_beat == 3'd7) r_w_done <= 1'b1;
                    end
                end
                WR_B: if (w_b_hs && m_axi.M_AXI_BRESP != 2'b00) r_err <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_line_master.sv
// tb/tb_axi_line_master.sv - randomized line master bench with RAM slave and line-level model
// Slave decides handshakes on the falling edge; driver and checker sample 1 time unit after rising.
module tb_axi_line_master;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_wr;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic         resp_valid;
    logic [255:0] resp_rdata;
    logic         resp_err;

    axi_line_master_if #(.ADDR_WIDTH(32)) m_axi ();

    axi_line_master #(.ADDR_WIDTH(32)) dut (
        .S_AXI_ACLK (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m_axi      (m_axi)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [31:0]  ram     [256];
    logic [31:0]  ref_mem [256];

    // driver-owned model state
    bit           cfg_rnd;
    int           cfg_rerr;
    int           cfg_rlast;
    bit           cfg_berr;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    logic [255:0] exp_wline;
    logic         exp_err;
    bit           exp_pending;
    logic [255:0] last_rd_line;
    int           clr_req;

    // checker-owned
    int           resp_seen;
    logic [255:0] last_rdata;

    // slave-owned
    int           s_wbeat, s_rbeat, last_hs, clr_seen;
    bit           s_rd_act, s_aw_got;
    logic [31:0]  s_araddr, s_awaddr;
    logic [31:0]  w_buf [8];
    bit           p_arv, p_awv, p_wv, p_wlast;
    logic [31:0]  p_araddr, p_awaddr, p_wdata;

    function automatic bit rnd_bit();
        return cfg_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    endfunction

    initial begin
        bit ar_hs, aw_hs, w_hs;
        logic [7:0] idx;
        m_axi.M_AXI_ARREADY = 0; m_axi.M_AXI_AWREADY = 0; m_axi.M_AXI_WREADY = 0;
        m_axi.M_AXI_RVALID = 0; m_axi.M_AXI_RDATA = 0; m_axi.M_AXI_RRESP = 0; m_axi.M_AXI_RLAST = 0;
        m_axi.M_AXI_BVALID = 0; m_axi.M_AXI_BRESP = 0;
        s_wbeat = 0; s_rbeat = 0; s_rd_act = 0; s_aw_got = 0; last_hs = -10; clr_seen = 0;
        p_arv = 0; p_awv = 0; p_wv = 0;
        forever begin
            @(negedge clk);
            if (rst || clr_req != clr_seen) begin
                clr_seen = clr_req;
                s_wbeat = 0; s_rbeat = 0; s_rd_act = 0; s_aw_got = 0;
                p_arv = 0; p_awv = 0; p_wv = 0;
                m_axi.M_AXI_ARREADY = 0; m_axi.M_AXI_AWREADY = 0; m_axi.M_AXI_WREADY = 0;
                m_axi.M_AXI_RVALID = 0; m_axi.M_AXI_BVALID = 0;
                continue;
            end
            if (p_arv) chk("ar_hold", {m_axi.M_AXI_ARVALID, m_axi.M_AXI_ARADDR}, {1'b1, p_araddr});
            if (p_awv) chk("aw_hold", {m_axi.M_AXI_AWVALID, m_axi.M_AXI_AWADDR}, {1'b1, p_awaddr});
            if (p_wv)  chk("w_hold", {m_axi.M_AXI_WVALID, m_axi.M_AXI_WDATA, m_axi.M_AXI_WLAST},
                           {1'b1, p_wdata, p_wlast});
            // R channel (started one cycle after the AR handshake)
            if (s_rd_act) begin
                idx = s_araddr[9:2] + 8'(s_rbeat);
                m_axi.M_AXI_RVALID = rnd_bit();
                m_axi.M_AXI_RDATA  = ram[idx];
                m_axi.M_AXI_RRESP  = (s_rbeat == cfg_rerr) ? 2'b10 : 2'b00;
                m_axi.M_AXI_RLAST  = (s_rbeat == cfg_rlast);
                if (m_axi.M_AXI_RVALID && m_axi.M_AXI_RREADY) begin
                    if (s_rbeat == 7) begin s_rd_act = 0; last_hs = cyc; end
                    s_rbeat++;
                end
            end else begin
                m_axi.M_AXI_RVALID = 0;
                m_axi.M_AXI_RDATA  = $urandom;
                m_axi.M_AXI_RLAST  = $urandom_range(0, 1);
            end
            m_axi.M_AXI_ARREADY = rnd_bit();
            ar_hs = m_axi.M_AXI_ARVALID && m_axi.M_AXI_ARREADY;
            if (ar_hs) begin
                chk("araddr", m_axi.M_AXI_ARADDR, exp_addr);
                chk("ar_const", {m_axi.M_AXI_ARLEN, m_axi.M_AXI_ARSIZE, m_axi.M_AXI_ARBURST},
                    {8'd7, 3'd2, 2'b01});
                s_araddr = m_axi.M_AXI_ARADDR; s_rd_act = 1; s_rbeat = 0;
            end
            p_arv = m_axi.M_AXI_ARVALID && !ar_hs; p_araddr = m_axi.M_AXI_ARADDR;
            m_axi.M_AXI_AWREADY = rnd_bit();
            aw_hs = m_axi.M_AXI_AWVALID && m_axi.M_AXI_AWREADY;
            if (aw_hs) begin
                chk("awaddr", m_axi.M_AXI_AWADDR, exp_addr);
                chk("aw_const", {m_axi.M_AXI_AWLEN, m_axi.M_AXI_AWSIZE, m_axi.M_AXI_AWBURST},
                    {8'd7, 3'd2, 2'b01});
                s_awaddr = m_axi.M_AXI_AWADDR; s_aw_got = 1;
            end
            p_awv = m_axi.M_AXI_AWVALID && !aw_hs; p_awaddr = m_axi.M_AXI_AWADDR;
            m_axi.M_AXI_WREADY = rnd_bit();
            if (m_axi.M_AXI_WVALID) chk("w_extra_beat", s_wbeat < 8, 1);
            w_hs = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY && s_wbeat < 8;
            if (w_hs) begin
                chk("wdata", m_axi.M_AXI_WDATA, exp_wline[32*s_wbeat +: 32]);
                chk("wlast", m_axi.M_AXI_WLAST, s_wbeat == 7);
                chk("wstrb", m_axi.M_AXI_WSTRB, 4'hF);
                w_buf[s_wbeat] = m_axi.M_AXI_WDATA;
                s_wbeat++;
            end
            p_wv = m_axi.M_AXI_WVALID && !w_hs;
            p_wdata = m_axi.M_AXI_WDATA; p_wlast = m_axi.M_AXI_WLAST;
            if (s_aw_got && s_wbeat == 8) begin
                if (!m_axi.M_AXI_BVALID) m_axi.M_AXI_BVALID = rnd_bit();
                m_axi.M_AXI_BRESP = cfg_berr ? 2'b10 : 2'b00;
                if (m_axi.M_AXI_BVALID && m_axi.M_AXI_BREADY) begin
                    for (int k = 0; k < 8; k++) ram[s_awaddr[9:2] + 8'(k)] = w_buf[k];
                    last_hs = cyc; s_aw_got = 0; s_wbeat = 0;
                end
            end else begin
                m_axi.M_AXI_BVALID = 0;
            end
        end
    end

    // every completion pulse is checked against the outstanding line-level expectation
    initial begin
        resp_seen = 0; last_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && resp_valid) begin
                chk("resp_expected", exp_pending, 1);
                if (exp_pending) begin
                    chk("resp_rdata", resp_rdata, exp_line);
                    chk("resp_err", resp_err, exp_err);
                    chk("resp_latency", cyc, last_hs + 1);
                end
                last_rdata = resp_rdata;
                resp_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [255:0] line,
                          input int rerr, input int rlast, input bit berr, input bit abort);
        int  base, seen0;
        bit  acc, got;
        base = int'(addr[9:5]) * 8;
        cfg_rerr = rerr; cfg_rlast = rlast; cfg_berr = berr;
        exp_addr = {addr[31:5], 5'b0}; exp_wline = line;
        if (wr) begin
            exp_line = last_rd_line; exp_err = berr;
        end else begin
            for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = ref_mem[base + k];
            exp_err = (rerr < 8) || (rlast != 7);
        end
        exp_pending = 1; seen0 = resp_seen;
        req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = line;
        acc = 0;
        for (int t = 0; t < 20 && !acc; t++) begin acc = req_ready; step(); end
        req_valid = 0; req_addr = $urandom; req_wdata = {8{$urandom}};
        chk("req_accept", acc, 1);
        chk("first_valid", {m_axi.M_AXI_ARVALID, m_axi.M_AXI_AWVALID, m_axi.M_AXI_WVALID},
            wr ? 3'b011 : 3'b100);
        if (abort) begin
            for (int t = 0; t < 50 && s_wbeat != 4; t++) step();
            chk("abort_point", s_wbeat, 4);
            rst = 1; step();
            chk("rst_outputs", {m_axi.M_AXI_ARVALID, m_axi.M_AXI_AWVALID, m_axi.M_AXI_WVALID,
                m_axi.M_AXI_RREADY, m_axi.M_AXI_BREADY, resp_valid, req_ready}, 7'b0000001);
            chk("rst_rdata", resp_rdata, '0);
            exp_pending = 0; clr_req++; rst = 0; last_rd_line = '0;
            repeat (20) step();
            chk("abort_no_resp", resp_seen, seen0);
            chk("abort_idle", req_ready, 1);
            return;
        end
        got = 0;
        for (int t = 0; t < 300 && !got; t++) begin step(); got = (resp_seen != seen0); end
        chk("resp_timeout", got, 1);
        repeat (3) step();
        chk("one_pulse", resp_seen - seen0, 1);
        chk("idle_after", req_ready, 1);
        exp_pending = 0;
        if (wr) begin
            for (int k = 0; k < 8; k++) ref_mem[base + k] = line[32*k +: 32];
        end else begin
            last_rd_line = exp_line;
        end
    endtask

    initial begin
        logic [255:0] line;
        bit           wr;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'hA000_0000 + i; ref_mem[i] = 32'hA000_0000 + i;
        end
        cfg_rnd = 0; cfg_rerr = 8; cfg_rlast = 7; cfg_berr = 0; clr_req = 0;
        exp_pending = 0; exp_addr = 0; exp_line = 0; exp_wline = 0; exp_err = 0; last_rd_line = '0;
        rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = '0;
        repeat (3) step();
        chk("reset_outputs", {m_axi.M_AXI_ARVALID, m_axi.M_AXI_AWVALID, m_axi.M_AXI_WVALID,
            m_axi.M_AXI_RREADY, m_axi.M_AXI_BREADY, resp_valid, resp_err, req_ready}, 8'b00000001);
        chk("reset_rdata", resp_rdata, '0);
        rst = 0; step();

        do_req(0, 32'h0000_0044, '0, 8, 7, 0, 0);
        chk("lit_araddr", s_araddr, 32'h40);
        chk("lit_rd_w0", last_rdata[31:0], 32'hA000_0010);
        chk("lit_rd_w7", last_rdata[255:224], 32'hA000_0017);

        for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'h1111_1111 * (k + 1);
        do_req(1, 32'h20, line, 8, 7, 0, 0);
        do_req(0, 32'h20, '0, 8, 7, 0, 0);
        chk("lit_rb_w0", last_rdata[31:0], 32'h1111_1111);
        chk("lit_rb_w7", last_rdata[255:224], 32'h8888_8888);

        cfg_rnd = 1;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            line = {8{$urandom}};
            for (int k = 0; k < 8; k++) line[32*k +: 32] = $urandom;
            do_req(wr, 32'($urandom_range(0, 1023)), line,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : 8, 7,
                   1'($urandom_range(0, 4) == 0), 0);
        end

        do_req(0, 32'h80, '0, 3, 7, 0, 0);
        chk("lit_rresp_err", last_rdata[31:0], ram[32]);
        do_req(1, 32'h1C0, {8{32'hCAFE_F00D}}, 8, 7, 1, 0);
        do_req(0, 32'h1C0, '0, 8, 7, 0, 0);
        do_req(0, 32'h3E0, '0, 8, 5, 0, 0);

        cfg_rnd = 0;
        do_req(1, 32'h100, {8{32'hDEAD_BEEF}}, 8, 7, 0, 1);
        do_req(0, 32'h100, '0, 8, 7, 0, 0);
        do_req(0, 32'h20, '0, 8, 7, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
